cl_frame_gen: RTL and testbench

//  Camera Link base-mode 2-tap video source: emits FVAL/LVAL/DVAL framing plus two pixels per CCLK
//  (DATA_L = even column, DATA_R = odd column), the transmit end of the stream the centroid block consumes.

---
 rtl/cl_frame_gen_if.sv | 45 ++++
 rtl/cl_frame_gen.sv | 216 +++++++++++++++++++++
 tb/tb_cl_frame_gen.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cl_frame_gen_if.sv
// cl_frame_gen_if: control inputs and Camera Link 2-tap framing/data outputs of cl_frame_gen.
// master = the frame generator, slave = the block that controls it and consumes the stream.
// CL_FRAME_GEN_BLOB_EN adds the iBLOB_X / iBLOB_Y / iBLOB_SIZE inputs.
interface cl_frame_gen_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int CNT_WIDTH   = 11
);
    logic                   iSTART;
    logic                   iFREERUN;
    logic [1:0]             iPATTERN;
    logic [PIXEL_WIDTH-1:0] iCONST;
`ifdef CL_FRAME_GEN_BLOB_EN
    logic [CNT_WIDTH-1:0]   iBLOB_X;
    logic [CNT_WIDTH-1:0]   iBLOB_Y;
    logic [CNT_WIDTH-1:0]   iBLOB_SIZE;
`endif
    logic                   oFVAL;
    logic                   oLVAL;
    logic                   oDVAL;
    logic [PIXEL_WIDTH-1:0] oDATA_L;
    logic [PIXEL_WIDTH-1:0] oDATA_R;
    logic                   oBUSY;
    logic                   oFRAME_DONE;
    logic [15:0]            oFRAME_CNT;

`ifdef CL_FRAME_GEN_BLOB_EN
    modport master (
        input  iSTART, iFREERUN, iPATTERN, iCONST, iBLOB_X, iBLOB_Y, iBLOB_SIZE,
        output oFVAL, oLVAL, oDVAL, oDATA_L, oDATA_R, oBUSY, oFRAME_DONE, oFRAME_CNT
    );
    modport slave (
        output iSTART, iFREERUN, iPATTERN, iCONST, iBLOB_X, iBLOB_Y, iBLOB_SIZE,
        input  oFVAL, oLVAL, oDVAL, oDATA_L, oDATA_R, oBUSY, oFRAME_DONE, oFRAME_CNT
    );
`else
    modport master (
        input  iSTART, iFREERUN, iPATTERN, iCONST,
        output oFVAL, oLVAL, oDVAL, oDATA_L, oDATA_R, oBUSY, oFRAME_DONE, oFRAME_CNT
    );
    modport slave (
        output iSTART, iFREERUN, iPATTERN, iCONST,
        input  oFVAL, oLVAL, oDVAL, oDATA_L, oDATA_R, oBUSY, oFRAME_DONE, oFRAME_CNT
    );
`endif
endinterface

// File: rtl/cl_frame_gen.sv
// cl_frame_gen: Camera Link base-mode 2-tap synthetic video source (FVAL/LVAL/DVAL + L/R pixels).
// Optional feature: define CL_FRAME_GEN_BLOB_EN to overlay an all-ones square blob on the pattern.
module cl_frame_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int CNT_WIDTH   = 11,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 16,
    parameter int FV_SETUP    = 4,
    parameter int FV_HOLD     = 4,
    parameter int V_BLANK     = 8
) (
    input  logic           CCLK,
    input  logic           RST_N,
    cl_frame_gen_if.master cl
);
    localparam int TW = 16;
    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(H_ACTIVE - 2);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(V_ACTIVE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LINE, S_HBLANK, S_HOLD, S_VBLANK
    } state_t;

    state_t                 r_state,     w_state_nxt;
    logic [TW-1:0]          r_timer,     w_timer_nxt;
    logic [CNT_WIDTH-1:0]   r_col,       w_col_nxt;
    logic [CNT_WIDTH-1:0]   r_row,       w_row_nxt;
    logic [CNT_WIDTH-1:0]   w_col1;
    logic [1:0]             r_pat,       w_pat_nxt;
    logic [PIXEL_WIDTH-1:0] r_const,     w_const_nxt;
`ifdef CL_FRAME_GEN_BLOB_EN
    logic [CNT_WIDTH-1:0]   r_bx,        w_bx_nxt;
    logic [CNT_WIDTH-1:0]   r_by,        w_by_nxt;
    logic [CNT_WIDTH-1:0]   r_bs,        w_bs_nxt;
`endif
    logic                   r_fval,      w_fval_nxt;
    logic                   r_lval,      w_lval_nxt;
    logic [PIXEL_WIDTH-1:0] r_dl,        w_dl_nxt;
    logic [PIXEL_WIDTH-1:0] r_dr,        w_dr_nxt;
    logic                   r_busy,      w_busy_nxt;
    logic                   r_done,      w_done_nxt;
    logic [15:0]            r_frame_cnt, w_cnt_nxt;

    // Base pattern value for pixel column x on line y, truncated to the pixel width.
    function automatic logic [PIXEL_WIDTH-1:0] f_pixel(
        input logic [CNT_WIDTH-1:0]   x,
        input logic [CNT_WIDTH-1:0]   y,
        input logic [1:0]             pat,
        input logic [PIXEL_WIDTH-1:0] cval
    );
        logic [PIXEL_WIDTH+CNT_WIDTH-1:0] w_xe;
        logic [PIXEL_WIDTH+CNT_WIDTH-1:0] w_ye;
        w_xe = {{PIXEL_WIDTH{1'b0}}, x};
        w_ye = {{PIXEL_WIDTH{1'b0}}, y};
        case (pat)
            2'd0:    f_pixel = w_xe[PIXEL_WIDTH-1:0];
            2'd1:    f_pixel = w_ye[PIXEL_WIDTH-1:0];
            2'd2:    f_pixel = (x[4] ^ y[4]) ? '1 : '0;
            default: f_pixel = cval;
        endcase
    endfunction

`ifdef CL_FRAME_GEN_BLOB_EN
    // One extra bit on the bounds so X+SIZE near the counter limit does not wrap.
    function automatic logic f_in_blob(
        input logic [CNT_WIDTH-1:0] x,
        input logic [CNT_WIDTH-1:0] y,
        input logic [CNT_WIDTH-1:0] bx,
        input logic [CNT_WIDTH-1:0] by,
        input logic [CNT_WIDTH-1:0] bs
    );
        f_in_blob = ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} < ({1'b0, bx} + {1'b0, bs})) &&
                    ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} < ({1'b0, by} + {1'b0, bs}));
    endfunction
`endif

    // Next-state, counters and next output values; outputs are registered from the next state.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_pat_nxt   = r_pat;
        w_const_nxt = r_const;
`ifdef CL_FRAME_GEN_BLOB_EN
        w_bx_nxt    = r_bx;
        w_by_nxt    = r_by;
        w_bs_nxt    = r_bs;
`endif
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_frame_cnt;
        case (r_state)
            S_IDLE: begin
                if (cl.iSTART | cl.iFREERUN) begin
                    w_state_nxt = S_SETUP;
                    w_timer_nxt = TW'(FV_SETUP - 1);
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_pat_nxt   = cl.iPATTERN;
                    w_const_nxt = cl.iCONST;
`ifdef CL_FRAME_GEN_BLOB_EN
                    w_bx_nxt    = cl.iBLOB_X;
                    w_by_nxt    = cl.iBLOB_Y;
                    w_bs_nxt    = cl.iBLOB_SIZE;
`endif
                end
            end
            S_SETUP: begin
                if (r_timer == '0) w_state_nxt = S_LINE;
                else               w_timer_nxt = r_timer - TW'(1);
            end
            S_LINE: begin
                if (r_col == COL_LAST) begin
                    if (r_row == ROW_LAST) begin
                        w_state_nxt = S_HOLD;
                        w_timer_nxt = TW'(FV_HOLD - 1);
                    end else begin
                        w_state_nxt = S_HBLANK;
                        w_timer_nxt = TW'(H_BLANK - 1);
                        w_row_nxt   = r_row + CNT_WIDTH'(1);
                        w_col_nxt   = '0;
                    end
                end else begin
                    w_col_nxt = r_col + CNT_WIDTH'(2);
                end
            end
            S_HBLANK: begin
                if (r_timer == '0) w_state_nxt = S_LINE;
                else               w_timer_nxt = r_timer - TW'(1);
            end
            S_HOLD: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_VBLANK;
                    w_timer_nxt = TW'(V_BLANK - 1);
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = r_frame_cnt + 16'd1;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            S_VBLANK: begin
                if (r_timer == '0) w_state_nxt = S_IDLE;
                else               w_timer_nxt = r_timer - TW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_col1     = w_col_nxt + CNT_WIDTH'(1);
        w_fval_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_VBLANK);
        w_lval_nxt = (w_state_nxt == S_LINE);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_dl_nxt   = '0;
        w_dr_nxt   = '0;
        if (w_lval_nxt) begin
            w_dl_nxt = f_pixel(w_col_nxt, w_row_nxt, w_pat_nxt, w_const_nxt);
            w_dr_nxt = f_pixel(w_col1, w_row_nxt, w_pat_nxt, w_const_nxt);
`ifdef CL_FRAME_GEN_BLOB_EN
            if (f_in_blob(w_col_nxt, w_row_nxt, w_bx_nxt, w_by_nxt, w_bs_nxt)) w_dl_nxt = '1;
            if (f_in_blob(w_col1, w_row_nxt, w_bx_nxt, w_by_nxt, w_bs_nxt))    w_dr_nxt = '1;
`endif
        end
    end

    // State, counters, latched frame settings and all output registers; async active-low reset.
    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_pat       <= '0;
            r_const     <= '0;
`ifdef CL_FRAME_GEN_BLOB_EN
            r_bx        <= '0;
            r_by        <= '0;
            r_bs        <= '0;
`endif
            r_fval      <= 1'b0;
            r_lval      <= 1'b0;
            r_dl        <= '0;
            r_dr        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_pat       <= w_pat_nxt;
            r_const     <= w_const_nxt;
`ifdef CL_FRAME_GEN_BLOB_EN
            r_bx        <= w_bx_nxt;
            r_by        <= w_by_nxt;
            r_bs        <= w_bs_nxt;
`endif
            r_fval      <= w_fval_nxt;
            r_lval      <= w_lval_nxt;
            r_dl        <= w_dl_nxt;
            r_dr        <= w_dr_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_frame_cnt <= w_cnt_nxt;
        end
    end

    assign cl.oFVAL       = r_fval;
    assign cl.oLVAL       = r_lval;
    assign cl.oDVAL       = r_lval;
    assign cl.oDATA_L     = r_dl;
    assign cl.oDATA_R     = r_dr;
    assign cl.oBUSY       = r_busy;
    assign cl.oFRAME_DONE = r_done;
    assign cl.oFRAME_CNT  = r_frame_cnt;
endmodule

// File: tb/tb_cl_frame_gen.sv
// tb_cl_frame_gen: self-checking bench for cl_frame_gen (small frame vs. a frame-position model,
// plus a larger frame for the pixel pattern table). Honours CL_FRAME_GEN_BLOB_EN when defined.
module tb_cl_frame_gen;
    localparam int HA = 8, VA = 3, HB = 2, FS = 2, FH = 2, VB = 3;
    localparam int LP   = HA / 2 + HB;
    localparam int FLEN = FS + VA * (HA / 2) + (VA - 1) * HB + FH;
    localparam int HA2 = 64, VA2 = 20;

    logic CCLK  = 1'b0;
    logic RST_N = 1'b0;
    always #5 CCLK = ~CCLK;

    cl_frame_gen_if #(.PIXEL_WIDTH(8), .CNT_WIDTH(11)) bus ();
    cl_frame_gen_if #(.PIXEL_WIDTH(8), .CNT_WIDTH(11)) bus2 ();

    cl_frame_gen #(.PIXEL_WIDTH(8), .CNT_WIDTH(11), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
                   .FV_SETUP(FS), .FV_HOLD(FH), .V_BLANK(VB))
        dut (.CCLK(CCLK), .RST_N(RST_N), .cl(bus));

    cl_frame_gen #(.PIXEL_WIDTH(8), .CNT_WIDTH(11), .H_ACTIVE(HA2), .V_ACTIVE(VA2), .H_BLANK(2),
                   .FV_SETUP(2), .FV_HOLD(2), .V_BLANK(3))
        dut2 (.CCLK(CCLK), .RST_N(RST_N), .cl(bus2));

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: frame position p counted from the first FVAL-high clock.
    bit          m_act   = 1'b0;
    int          m_p     = 0;
    logic [15:0] m_cnt   = '0;
    logic [1:0]  m_pat   = '0;
    logic [7:0]  m_const = '0;
    int          m_bx = 0, m_by = 0, m_bs = 0;

    always @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            m_act <= 1'b0;
            m_p   <= 0;
            m_cnt <= '0;
        end else if (m_act) begin
            if (m_p == FLEN + VB - 1) m_act <= 1'b0;
            else begin
                m_p <= m_p + 1;
                if (m_p + 1 == FLEN) m_cnt <= m_cnt + 16'd1;
            end
        end else if (bus.iSTART || bus.iFREERUN) begin
            m_act   <= 1'b1;
            m_p     <= 0;
            m_pat   <= bus.iPATTERN;
            m_const <= bus.iCONST;
`ifdef CL_FRAME_GEN_BLOB_EN
            m_bx    <= int'(bus.iBLOB_X);
            m_by    <= int'(bus.iBLOB_Y);
            m_bs    <= int'(bus.iBLOB_SIZE);
`endif
        end
    end

    function automatic logic [7:0] pix(int x, int y);
        logic [7:0] v;
        case (m_pat)
            2'd0:    v = 8'(x);
            2'd1:    v = 8'(y);
            2'd2:    v = (((x / 16) % 2) != ((y / 16) % 2)) ? 8'hFF : 8'h00;
            default: v = m_const;
        endcase
        if (x >= m_bx && x < m_bx + m_bs && y >= m_by && y < m_by + m_bs) v = 8'hFF;
        return v;
    endfunction

    function automatic logic [63:0] exp_vec();
        logic fv, lv, bz, dn;
        logic [7:0] l, r;
        int q, row, col;
        fv = 0; lv = 0; bz = 0; dn = 0; l = '0; r = '0;
        if (m_act) begin
            bz = 1'b1;
            fv = (m_p < FLEN);
            dn = (m_p == FLEN);
            q  = m_p - FS;
            if (q >= 0 && q < VA * LP - HB && (q % LP) < HA / 2) begin
                lv  = 1'b1;
                row = q / LP;
                col = 2 * (q % LP);
                l   = pix(col, row);
                r   = pix(col + 1, row);
            end
        end
        return {27'd0, fv, lv, lv, l, r, bz, dn, m_cnt};
    endfunction

    function automatic logic [63:0] act_vec();
        return {27'd0, bus.oFVAL, bus.oLVAL, bus.oDVAL, bus.oDATA_L, bus.oDATA_R,
                bus.oBUSY, bus.oFRAME_DONE, bus.oFRAME_CNT};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: compare the DUT against the model on the falling edge, then leave the edge.
    task automatic step();
        @(negedge CCLK);
        check("cycle", act_vec(), exp_vec());
        #1;
    endtask

    // Stream monitor for the small instance.
    logic       pf = 1'b0, pl = 1'b0, first_seen = 1'b0;
    int         frames = 0, low_run = 0, lval_rises = 0, done_pulses = 0, ff_cnt = 0;
    int         gaps [64];
    logic [7:0] first_l [64];
    logic [7:0] last_l  [64];
    always @(negedge CCLK) begin
        pf <= bus.oFVAL;
        pl <= bus.oLVAL;
        if (!bus.oFVAL) low_run <= low_run + 1;
        else if (!pf) begin
            gaps[(frames + 1) % 64] <= low_run;
            low_run    <= 0;
            frames     <= frames + 1;
            first_seen <= 1'b0;
        end
        if (bus.oLVAL && !pl) lval_rises <= lval_rises + 1;
        if (bus.oFRAME_DONE)  done_pulses <= done_pulses + 1;
        if (bus.oDVAL) begin
            if (!first_seen) begin
                first_l[frames % 64] <= bus.oDATA_L;
                first_seen <= 1'b1;
            end
            last_l[frames % 64] <= bus.oDATA_L;
            ff_cnt <= ff_cnt + ((bus.oDATA_L == 8'hFF) ? 1 : 0) + ((bus.oDATA_R == 8'hFF) ? 1 : 0);
        end
    end

    // Pixel capture for the large instance, indexed by line and column pair.
    logic [7:0] cap_l [VA2][HA2/2];
    logic [7:0] cap_r [VA2][HA2/2];
    int   r2 = -1, c2 = 0;
    logic p2l = 1'b0;
    always @(negedge CCLK) begin
        p2l <= bus2.oLVAL;
        if (!bus2.oFVAL) begin
            r2 <= -1;
            c2 <= 0;
        end else if (bus2.oLVAL) begin
            if (!p2l) begin
                if (r2 + 1 < VA2) begin
                    cap_l[r2 + 1][0] <= bus2.oDATA_L;
                    cap_r[r2 + 1][0] <= bus2.oDATA_R;
                end
                r2 <= r2 + 1;
                c2 <= 2;
            end else begin
                if (r2 >= 0 && r2 < VA2 && c2 < HA2) begin
                    cap_l[r2][c2 / 2] <= bus2.oDATA_L;
                    cap_r[r2][c2 / 2] <= bus2.oDATA_R;
                end
                c2 <= c2 + 2;
            end
        end
    end

    typedef struct {
        logic [1:0] pat;
        logic [7:0] cval;
        int         row;
        int         col;
        logic [7:0] el;
        logic [7:0] er;
    } vec_t;
    vec_t tbl [15];

    task automatic pulse_start(input logic [1:0] pat, input logic [7:0] cval);
        bus.iPATTERN = pat;
        bus.iCONST   = cval;
        bus.iSTART   = 1'b1;
        step();
        bus.iSTART   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.oBUSY && n < 200) begin step(); n++; end
        check(name, 64'(n < 200), 64'd1);
    endtask

    task automatic run_frame2(input logic [1:0] pat, input logic [7:0] cval);
        int n;
        bus2.iPATTERN = pat;
        bus2.iCONST   = cval;
        bus2.iSTART   = 1'b1;
        step();
        bus2.iSTART   = 1'b0;
        n = 0;
        while (!bus2.oFRAME_DONE && n < 2000) begin step(); n++; end
        check("big_frame_done", 64'(n < 2000), 64'd1);
        n = 0;
        while (bus2.oBUSY && n < 50) begin step(); n++; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base_cnt, base_fr, base_done, base_lr, base_ff;
        logic [1:0] cur_pat;
        logic [7:0] cur_c;
        bit have;

        tbl[0]  = '{2'd0, 8'h00,  5, 62, 8'd62,  8'd63};
        tbl[1]  = '{2'd0, 8'h00,  0,  0, 8'd0,   8'd1};
        tbl[2]  = '{2'd0, 8'h00, 19, 16, 8'd16,  8'd17};
        tbl[3]  = '{2'd1, 8'h00, 19, 10, 8'd19,  8'd19};
        tbl[4]  = '{2'd1, 8'h00,  7,  0, 8'd7,   8'd7};
        tbl[5]  = '{2'd2, 8'h00,  0,  0, 8'h00,  8'h00};
        tbl[6]  = '{2'd2, 8'h00,  0, 16, 8'hFF,  8'hFF};
        tbl[7]  = '{2'd2, 8'h00,  0, 30, 8'hFF,  8'hFF};
        tbl[8]  = '{2'd2, 8'h00,  0, 32, 8'h00,  8'h00};
        tbl[9]  = '{2'd2, 8'h00, 16,  0, 8'hFF,  8'hFF};
        tbl[10] = '{2'd2, 8'h00, 16, 16, 8'h00,  8'h00};
        tbl[11] = '{2'd2, 8'h00, 19, 48, 8'h00,  8'h00};
        tbl[12] = '{2'd2, 8'h00, 15, 48, 8'hFF,  8'hFF};
        tbl[13] = '{2'd3, 8'hA5,  7, 20, 8'hA5,  8'hA5};
        tbl[14] = '{2'd3, 8'hA5, 19, 62, 8'hA5,  8'hA5};

        bus.iSTART = 0;  bus.iFREERUN = 0;  bus.iPATTERN = 0;  bus.iCONST = 0;
        bus2.iSTART = 0; bus2.iFREERUN = 0; bus2.iPATTERN = 0; bus2.iCONST = 0;
`ifdef CL_FRAME_GEN_BLOB_EN
        bus.iBLOB_X = 0;  bus.iBLOB_Y = 0;  bus.iBLOB_SIZE = 0;
        bus2.iBLOB_X = 0; bus2.iBLOB_Y = 0; bus2.iBLOB_SIZE = 0;
`endif
        // Reset, then idle for 100 clocks with everything low.
        repeat (5) step();
        RST_N = 1'b1;
        repeat (100) step();
        check("idle_outputs", act_vec(), 64'd0);

        // Single frame, pattern 0.
        base_lr = lval_rises; base_done = done_pulses;
        pulse_start(2'd0, 8'h00);
        check("fval_rise", 64'(bus.oFVAL), 64'd1);
        n = 0;
        while (!bus.oFRAME_DONE && n < 200) begin step(); n++; end
        check("frame1_done_seen", 64'(n < 200), 64'd1);
        wait_idle("frame1_idle");
        check("frame1_lval_bursts", 64'(lval_rises - base_lr), 64'd3);
        check("frame1_done_pulses", 64'(done_pulses - base_done), 64'd1);
        check("frame1_cnt", 64'(bus.oFRAME_CNT), 64'd1);

        // Free-running, three frames; pattern change during frame 2 lands on frame 3.
        base_fr = frames; base_done = done_pulses; base_cnt = int'(bus.oFRAME_CNT);
        bus.iPATTERN = 2'd1;
        bus.iFREERUN = 1'b1;
        n = 0;
        while (frames < base_fr + 2 && n < 200) begin step(); n++; end
        check("freerun_frame2_start", 64'(n < 200), 64'd1);
        repeat (5) step();
        bus.iPATTERN = 2'd3;
        bus.iCONST   = 8'h3C;
        n = 0;
        while (done_pulses < base_done + 3 && n < 300) begin step(); n++; end
        check("freerun_three_done", 64'(n < 300), 64'd1);
        bus.iFREERUN = 1'b0;
        wait_idle("freerun_idle");
        check("gap_1_2", 64'(gaps[(base_fr + 2) % 64]), 64'(VB + 1));
        check("gap_2_3", 64'(gaps[(base_fr + 3) % 64]), 64'(VB + 1));
        check("frame2_last_l", 64'(last_l[(base_fr + 2) % 64]), 64'd2);
        check("frame3_first_l", 64'(first_l[(base_fr + 3) % 64]), 64'h3C);
        check("freerun_cnt", 64'(bus.oFRAME_CNT), 64'(base_cnt + 3));
        repeat (10) step();
        check("freerun_stopped", 64'(frames), 64'(base_fr + 3));

        // iSTART during LINE is ignored.
        base_fr = frames; base_cnt = int'(bus.oFRAME_CNT);
        pulse_start(2'd0, 8'h00);
        n = 0;
        while (!bus.oLVAL && n < 20) begin step(); n++; end
        check("line_reached", 64'(n < 20), 64'd1);
        bus.iSTART = 1'b1;
        step();
        bus.iSTART = 1'b0;
        wait_idle("start_ignored_idle");
        repeat (10) step();
        check("start_ignored_busy", 64'(bus.oBUSY), 64'd0);
        check("start_ignored_cnt", 64'(bus.oFRAME_CNT), 64'(base_cnt + 1));
        check("start_ignored_frames", 64'(frames), 64'(base_fr + 1));

        // Asynchronous reset during row 1, then a clean frame from row 0.
        base_lr = lval_rises;
        pulse_start(2'd1, 8'h00);
        n = 0;
        while (lval_rises < base_lr + 2 && n < 50) begin step(); n++; end
        check("row1_reached", 64'(n < 50), 64'd1);
        @(posedge CCLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_reset_outputs", act_vec(), 64'd0);
        repeat (2) step();
        RST_N = 1'b1;
        step();
        pulse_start(2'd1, 8'h00);
        n = 0;
        while (!bus.oDVAL && n < 20) begin step(); n++; end
        check("post_reset_dval", 64'(n < 20), 64'd1);
        check("post_reset_first_lr", {48'd0, bus.oDATA_L, bus.oDATA_R}, 64'd0);
        wait_idle("post_reset_idle");
        check("post_reset_cnt", 64'(bus.oFRAME_CNT), 64'd1);

`ifdef CL_FRAME_GEN_BLOB_EN
        // Blob over a constant background.
        base_ff = ff_cnt;
        bus.iBLOB_X = 11'd2; bus.iBLOB_Y = 11'd1; bus.iBLOB_SIZE = 11'd2;
        pulse_start(2'd3, 8'h10);
        wait_idle("blob_idle");
        check("blob_ff_pixels", 64'(ff_cnt - base_ff), 64'd4);
        bus.iBLOB_SIZE = 11'd0;
`else
        base_ff = ff_cnt;
        pulse_start(2'd3, 8'h10);
        wait_idle("const_idle");
        check("const_no_ff", 64'(ff_cnt - base_ff), 64'd0);
`endif

        // Pattern table on the large frame.
        have = 1'b0; cur_pat = '0; cur_c = '0;
        for (int i = 0; i < 15; i++) begin
            if (!have || tbl[i].pat != cur_pat || tbl[i].cval != cur_c) begin
                run_frame2(tbl[i].pat, tbl[i].cval);
                cur_pat = tbl[i].pat;
                cur_c   = tbl[i].cval;
                have    = 1'b1;
            end
            check($sformatf("tbl%0d_pat%0d_r%0d_c%0d", i, tbl[i].pat, tbl[i].row, tbl[i].col),
                  {48'd0, cap_l[tbl[i].row][tbl[i].col / 2], cap_r[tbl[i].row][tbl[i].col / 2]},
                  {48'd0, tbl[i].el, tbl[i].er});
        end

        // Randomised control traffic against the model.
        for (int k = 0; k < 600; k++) begin
            bus.iSTART   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) bus.iFREERUN = ~bus.iFREERUN;
            bus.iPATTERN = 2'($urandom_range(0, 3));
            bus.iCONST   = 8'($urandom);
`ifdef CL_FRAME_GEN_BLOB_EN
            bus.iBLOB_X    = 11'($urandom_range(0, 8));
            bus.iBLOB_Y    = 11'($urandom_range(0, 3));
            bus.iBLOB_SIZE = 11'($urandom_range(0, 4));
`endif
            step();
        end
        bus.iSTART   = 1'b0;
        bus.iFREERUN = 1'b0;
        wait_idle("random_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
